// File: rtl/relay_path_arb_if.sv
// Handshake bundle between the relay/input-select requesters and the
// path arbiter. The requesters (master side) drive level requests and
// error-clear pulses. The arbiter (slave side) returns grant, settle and
// status information.
interface relay_path_arb_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] err_clr;
  logic [N_REQ-1:0] grant;
  logic             settled;
  logic             busy;
  logic [ID_W-1:0]  owner_id;
  logic [N_REQ-1:0] timeout_err;

  modport master (
    output req, err_clr,
    input  grant, settled, busy, owner_id, timeout_err
  );

  modport slave (
    input  req, err_clr,
    output grant, settled, busy, owner_id, timeout_err
  );
endinterface

// File: rtl/relay_path_arb.sv
// Exclusive-ownership arbiter for the shared relay / input-select path.
// grant[i] drives the i-th *_active interlock. Each new owner gets a relay
// settle delay before settled rises, every release is followed by a
// break-before-make guard gap, and an owner that holds the path too long
// is forced off and flagged in timeout_err.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | path free, round-robin arbitration over unmasked requests
//   S_SETTLE | grant driven, waiting SETTLE_CYC cycles for relay settle
//   S_OWN    | settled high, owner uses path, hold time counted
//   S_GUARD  | grant low for GUARD_CYC cycles before next arbitration
module relay_path_arb #(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 16,
  parameter int GUARD_CYC  = 4,
  parameter int HOLD_MAX   = 1000,
  parameter int CNT_W      = 8,
  parameter int HCNT_W     = 16
) (
  input logic             clk,
  input logic             rst_,
  relay_path_arb_if.slave bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Counter reload values are "cycles minus one" so that the terminal
  // compare against zero (or HOLD_LAST) lands on the exact edge.
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  GUARD_LOAD  = CNT_W'(GUARD_CYC - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OWN    = 2'd2,
    S_GUARD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic              r_settled;
  logic              r_busy;
  logic [ID_W-1:0]   r_owner;
  logic [ID_W-1:0]   r_rr;
  logic [CNT_W-1:0]  r_cnt;
  logic [HCNT_W-1:0] r_hold;
  logic [N_REQ-1:0]  r_err;
  logic [N_REQ-1:0]  r_mask;

  logic [N_REQ-1:0]  w_cand;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [N_REQ-1:0]  w_win_oh;
  logic              w_owner_req;

  // A requester that was force-released stays out of arbitration until
  // its request has been seen low once.
  assign w_cand      = bus.req & ~r_mask;
  assign w_owner_req = bus.req[r_owner];

  // Round-robin search starting just after the last grantee.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_idx    = '0;
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr) + k) % N_REQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found         = 1'b1;
        w_win           = w_idx;
        w_win_oh        = '0;
        w_win_oh[w_idx] = 1'b1;
      end
    end
  end

  // Ownership sequencer: arbitration, settle, hold watchdog, guard gap.
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_settled <= 1'b0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_rr      <= ID_W'(N_REQ - 1);
      r_cnt     <= '0;
      r_hold    <= '0;
      r_err     <= '0;
      r_mask    <= '0;
    end else begin
      // Later assignments in the case below override these, so a timeout
      // set wins over a same-edge err_clr.
      r_err  <= r_err & ~bus.err_clr;
      r_mask <= r_mask & bus.req;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_win_oh;
            r_owner <= w_win;
            r_rr    <= w_win;
            r_cnt   <= SETTLE_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_cnt   <= GUARD_LOAD;
            r_state <= S_GUARD;
          end else if (r_cnt == '0) begin
            r_settled <= 1'b1;
            r_hold    <= '0;
            r_state   <= S_OWN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_OWN: begin
          if (!w_owner_req) begin
            r_grant   <= '0;
            r_settled <= 1'b0;
            r_cnt     <= GUARD_LOAD;
            r_state   <= S_GUARD;
          end else if (r_hold == HOLD_LAST) begin
            r_grant         <= '0;
            r_settled       <= 1'b0;
            r_cnt           <= GUARD_LOAD;
            r_err[r_owner]  <= 1'b1;
            r_mask[r_owner] <= 1'b1;
            r_state         <= S_GUARD;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        S_GUARD: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_grant   <= '0;
          r_settled <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.settled     = r_settled;
  assign bus.busy        = r_busy;
  assign bus.owner_id    = r_owner;
  assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_relay_path_arb.sv
// Testbench for relay_path_arb. The driver applies inputs on the falling
// edge, advances a timeline-based reference model and queues the expected
// outputs; an independent monitor pops and compares after every rising
// edge. Directed scenarios add targeted checks on observed grant history.
module tb_relay_path_arb;
  localparam int N   = 4;
  localparam int SC  = 16;
  localparam int GC  = 4;
  localparam int HM  = 1000;
  localparam int IDW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]   grant;
    logic           settled;
    logic           busy;
    logic [IDW-1:0] owner_id;
    logic [N-1:0]   err;
  } out_t;

  logic clk = 1'b0;
  logic rst_;

  relay_path_arb_if #(.N_REQ(N)) bus ();

  relay_path_arb #(
    .N_REQ(N), .SETTLE_CYC(SC), .GUARD_CYC(GC), .HOLD_MAX(HM),
    .CNT_W(8), .HCNT_W(16)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  out_t exp_q[$];

  // Reference model: ownership described by the edge index of the grant
  // and of the release; all timing is derived from those time stamps.
  int           now    = 0;
  int           m_own  = -1;
  int           m_tg   = 0;
  int           m_tr   = 0;
  bit           m_gap  = 1'b0;
  int           m_rr   = N - 1;
  int           m_last = 0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_err  = '0;

  // Monitor-observed grant history.
  logic [N-1:0] obs_grant[$];
  int           obs_gap[$];
  logic [N-1:0] mon_prev    = '0;
  int           mon_zrun    = 0;
  int           mon_hrun    = 0;
  bit           mon_sset    = 1'b0;
  int           mon_lastlen = 0;
  bit           mon_lastset = 1'b0;
  int           mon_cyc     = 0;

  logic [N-1:0] exp_order[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  function automatic void model_step(input logic r, input logic [N-1:0] rq,
                                     input logic [N-1:0] clr);
    logic [N-1:0] set_b;
    bit           done;
    int           j;
    set_b = '0;
    done  = 1'b0;
    now++;
    if (r) begin
      m_own  = -1;
      m_gap  = 1'b0;
      m_rr   = N - 1;
      m_last = 0;
      m_mask = '0;
      m_err  = '0;
      return;
    end
    if (m_own >= 0) begin
      if (!rq[m_own]) begin
        m_own = -1; m_gap = 1'b1; m_tr = now;
      end else if (now - m_tg == SC + HM) begin
        set_b[m_own] = 1'b1;
        m_own = -1; m_gap = 1'b1; m_tr = now;
      end
    end else if (m_gap) begin
      if (now - m_tr == GC) m_gap = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_rr + k) % N;
        if (!done && rq[j] && !m_mask[j]) begin
          done = 1'b1; m_own = j; m_tg = now; m_rr = j; m_last = j;
        end
      end
    end
    m_mask = (m_mask & rq) | set_b;
    m_err  = (m_err & ~clr) | set_b;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.grant    = (m_own >= 0) ? (N'(1) << m_own) : '0;
    o.settled  = (m_own >= 0) && (now - m_tg >= SC);
    o.busy     = (m_own >= 0) || m_gap;
    o.owner_id = IDW'(m_last);
    o.err      = m_err;
    return o;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] clr);
    @(negedge clk);
    rst_        = r;
    bus.req     = rq;
    bus.err_clr = clr;
    model_step(r, rq, clr);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: scoreboard compare plus grant history capture.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      a = {bus.grant, bus.settled, bus.busy, bus.owner_id, bus.timeout_err};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs cyc %0d: got grant=%b settled=%b busy=%b owner=%0d err=%b, expected grant=%b settled=%b busy=%b owner=%0d err=%b",
                   mon_cyc, a.grant, a.settled, a.busy, a.owner_id, a.err,
                   e.grant, e.settled, e.busy, e.owner_id, e.err);
        end
        n_cmp++;
        if (!$onehot0(bus.grant)) begin
          n_bad++;
          $display("FAIL grant_onehot cyc %0d: got %b, expected one-hot or zero", mon_cyc, bus.grant);
        end
      end
      if (bus.grant != '0) begin
        if (mon_prev == '0) begin
          obs_grant.push_back(bus.grant);
          obs_gap.push_back(mon_zrun);
          mon_hrun = 0;
          mon_sset = 1'b0;
        end
        mon_hrun++;
        if (bus.settled) mon_sset = 1'b1;
        mon_zrun = 0;
      end else begin
        if (mon_prev != '0) begin
          mon_lastlen = mon_hrun;
          mon_lastset = mon_sset;
        end
        mon_zrun++;
      end
      mon_prev = bus.grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           base;
    logic [N-1:0] rq, clr, cur;
    int           hold;
    bit           hit;

    rst_        = 1'b1;
    bus.req     = '0;
    bus.err_clr = '0;

    // Reset, single requester, settle, release, guard.
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    chk("reset_grant", 32'(bus.grant), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    step(1'b0, 4'b0001, '0);
    step(1'b0, 4'b0001, '0);
    chk("first_grant", 32'(bus.grant), 32'b0001);
    chk("first_busy", 32'(bus.busy), 1);
    for (int i = 0; i < SC + 2; i++) step(1'b0, 4'b0001, '0);
    chk("first_settled", 32'(bus.settled), 1);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    chk("drop_grant", 32'(bus.grant), 0);
    chk("drop_busy", 32'(bus.busy), 1);
    idle(GC + 1);
    chk("guard_done_busy", 32'(bus.busy), 0);

    // Round robin with all four requesting, each dropping after 5 OWN cycles.
    step(1'b1, '0, '0);
    base = obs_grant.size();
    for (int i = 0; i < 300 && obs_grant.size() < base + 5; i++) begin
      rq = 4'b1111;
      if (m_own >= 0 && (now - m_tg) >= SC + 4) rq[m_own] = 1'b0;
      step(1'b0, rq, '0);
    end
    chk("rr_count", 32'(obs_grant.size() - base), 5);
    if (obs_grant.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_order[%0d]", i), 32'(obs_grant[base + i]), 32'(exp_order[i]));
        if (i > 0) chk($sformatf("rr_gap[%0d]", i), 32'(obs_gap[base + i]), GC + 1);
      end
    end
    idle(SC + GC + 8);

    // Short pulse on requester 2: released during settle, never settled.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, '0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    chk("pulse_len", 32'(mon_lastlen), 3);
    chk("pulse_settled", 32'(mon_lastset), 0);
    chk("pulse_guard_busy", 32'(bus.busy), 1);
    chk("pulse_no_err", 32'(bus.timeout_err), 0);
    idle(GC + 2);

    // Hold timeout on requester 1.
    base = obs_grant.size();
    for (int i = 0; i < 1200; i++) step(1'b0, 4'b0010, '0);
    chk("timeout_err", 32'(bus.timeout_err), 32'b0010);
    chk("timeout_no_regrant", 32'(obs_grant.size() - base), 1);
    chk("timeout_grant_low", 32'(bus.grant), 0);
    step(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, '0);
    chk("regrant_after_low", 32'(bus.grant), 32'b0010);
    chk("err_sticky", 32'(bus.timeout_err), 32'b0010);
    idle(GC + 2);
    step(1'b0, '0, 4'b0010);
    step(1'b0, '0, '0);
    chk("err_clr", 32'(bus.timeout_err), 0);

    // Reset while owning; round-robin pointer must return to its reset value.
    for (int i = 0; i < SC + 3; i++) step(1'b0, 4'b0001, '0);
    chk("pre_rst_settled", 32'(bus.settled), 1);
    step(1'b1, 4'b0001, '0);
    step(1'b0, 4'b1001, '0);
    chk("rst_outputs", 32'({bus.grant, bus.settled, bus.busy, bus.owner_id, bus.timeout_err}), 0);
    step(1'b0, 4'b1001, '0);
    chk("rst_rr_restored", 32'(bus.grant), 32'b0001);
    idle(GC + 3);

    // err_clr on the same edge as a timeout set: the set wins.
    hit = 1'b0;
    for (int i = 0; i < SC + HM + 50 && !hit; i++) begin
      clr = '0;
      if (m_own == 3 && (now + 1 - m_tg) == SC + HM) begin
        clr = 4'b1000;
        hit = 1'b1;
      end
      step(1'b0, 4'b1000, clr);
    end
    step(1'b0, 4'b1000, '0);
    chk("set_beats_clr", 32'(bus.timeout_err[3]), 1);
    chk("set_beats_clr_owner", 32'(bus.owner_id), 3);
    idle(GC + 2);

    // Randomized traffic against the reference model.
    hold = 0;
    cur  = '0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        cur  = N'($urandom_range(0, 15));
        hold = $urandom_range(1, 40);
      end
      hold--;
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      step(($urandom_range(0, 599) == 0), cur, clr);
    end

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
